// File: rtl/decodificador7seg_pkg.sv
// Shared constants for the 7-segment display bus receiver: segment codes,
// digit-enable patterns and the frame-capture FSM encoding.
package decodificador7seg_pkg;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low one-hot digit enables
    localparam logic [3:0] EN_D0   = 4'b1110;
    localparam logic [3:0] EN_D1   = 4'b1101;
    localparam logic [3:0] EN_D2   = 4'b1011;
    localparam logic [3:0] EN_D3   = 4'b0111;
    localparam logic [3:0] EN_IDLE = 4'b1111;

    localparam int NUM_DIG = 3;  // ones, tens, hundreds carry data; D3 must be blank

    typedef enum logic [1:0] {
        ESPERA_D0 = 2'd0,
        ESPERA_D1 = 2'd1,
        ESPERA_D2 = 2'd2,
        ESPERA_D3 = 2'd3
    } estado_t;

    // Enable pattern the FSM expects to see while waiting in a given state
    function automatic logic [3:0] en_esperado(estado_t s);
        case (s)
            ESPERA_D0: en_esperado = EN_D0;
            ESPERA_D1: en_esperado = EN_D1;
            ESPERA_D2: en_esperado = EN_D2;
            default:   en_esperado = EN_D3;
        endcase
    endfunction

    // Exactly one bit low
    function automatic logic one_hot_low(logic [3:0] en);
        one_hot_low = (en == EN_D0) || (en == EN_D1) ||
                      (en == EN_D2) || (en == EN_D3);
    endfunction

endpackage

// File: rtl/decodificador7seg_sevenSeg2bcd.sv
// Combinational reverse decoder: active-low segment byte -> BCD digit.
// Anything that is not one of the ten digit glyphs (blank included) is flagged
// as not legal, so callers only need one bit to reject a digit slot.
module sevenSeg2bcd
    import decodificador7seg_pkg::*;
(
    input  logic [7:0] seg,
    output logic       legal,
    output logic [3:0] bcd
);

    // Exact pattern match; a lit dp or any letter falls to the default
    always_comb begin
        legal = 1'b1;
        bcd   = 4'd0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/decodificador7seg.sv
// Display bus receiver: samples the multiplexed 7-segment bus, reassembles
// ones/tens/hundreds of one scan frame, decodes back to BCD/binary and
// publishes a value only after ESTAVEIS identical good frames.
module decodificador7seg
    import decodificador7seg_pkg::*;
#(
    parameter int ESTAVEIS = 2,   // 1..15
    parameter int TIMEOUT  = 64   // >= 8
) (
    input  logic        clock,
    input  logic        zera_as_n,
    input  logic [11:0] display,
    output logic [7:0]  numero,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic        valido,
    output logic        pronto,
    output logic        erro,
    output logic [1:0]  db_estado
);

    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  CNT_MAX = 4'(ESTAVEIS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [3:0] en;
    logic [7:0] seg;
    assign en  = display[11:8];
    assign seg = display[7:0];

    // FSM and classification
    estado_t estado, estado_n;
    logic [NUM_DIG-1:0] cap_we;
    logic               eval;      // D3 accepted in ESPERA_D3: judge the frame
    logic               seq_err;   // enable out of order or malformed
    logic               tmo_inc, tmo_clr, tmo_hit;
    logic [TW-1:0]      tmo_cnt;

    // Captured segment bytes: [0]=ones, [1]=tens, [2]=hundreds
    logic [NUM_DIG-1:0][7:0] seg_cap;
    logic [NUM_DIG-1:0][3:0] dig;
    logic [NUM_DIG-1:0]      dig_ok;

    // Frame evaluation
    logic [9:0] valor;
    logic       frame_ok, good, bad_frame, err_any;
    logic [3:0] cnt, cnt_inc, cnt_good;
    logic [7:0] cand;
    logic       publish;

    assign tmo_hit = tmo_inc && (tmo_cnt == TMO_LAST);

    // State register
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) estado <= ESPERA_D0;
        else            estado <= estado_n;
    end

    // Next state: classify the enable nibble against the expected position
    always_comb begin
        estado_n = estado;
        cap_we   = '0;
        eval     = 1'b0;
        seq_err  = 1'b0;
        tmo_inc  = 1'b0;
        tmo_clr  = 1'b0;
        if (en == EN_IDLE) begin
            tmo_inc = 1'b1;
            if (tmo_hit) estado_n = ESPERA_D0;
        end else if (one_hot_low(en)) begin
            tmo_clr = 1'b1;
            if (en == en_esperado(estado)) begin
                case (estado)
                    ESPERA_D0: begin cap_we[0] = 1'b1; estado_n = ESPERA_D1; end
                    ESPERA_D1: begin cap_we[1] = 1'b1; estado_n = ESPERA_D2; end
                    ESPERA_D2: begin cap_we[2] = 1'b1; estado_n = ESPERA_D3; end
                    default:   begin eval      = 1'b1; estado_n = ESPERA_D0; end
                endcase
            end else begin
                // Out-of-order digit: a fresh D0 restarts the frame right away
                seq_err = 1'b1;
                if (en == EN_D0) begin
                    cap_we[0] = 1'b1;
                    estado_n  = ESPERA_D1;
                end else begin
                    estado_n  = ESPERA_D0;
                end
            end
        end else begin
            seq_err  = 1'b1;
            estado_n = ESPERA_D0;
        end
    end

    // Segment capture for the three data positions
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            seg_cap <= '0;
        end else begin
            for (int i = 0; i < NUM_DIG; i++)
                if (cap_we[i]) seg_cap[i] <= seg;
        end
    end

    // One reverse decoder per captured digit
    genvar g;
    generate
        for (g = 0; g < NUM_DIG; g++) begin : g_dec
            sevenSeg2bcd u_dec (
                .seg   (seg_cap[g]),
                .legal (dig_ok[g]),
                .bcd   (dig[g])
            );
        end
    endgenerate

    // Frame judgement; the D3 byte is checked straight off the bus
    always_comb begin
        valor     = 10'(dig[2]) * 10'd100 + 10'(dig[1]) * 10'd10 + 10'(dig[0]);
        frame_ok  = (&dig_ok) && (seg == SEG_BLANK) && (valor <= 10'd255);
        good      = eval && frame_ok;
        bad_frame = eval && !frame_ok;
        err_any   = seq_err || bad_frame;
    end

    // Stability counter arithmetic and publish decision
    always_comb begin
        cnt_inc  = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 4'd1;
        cnt_good = (valor[7:0] == cand) ? cnt_inc : 4'd1;
        publish  = good && (cnt_good == CNT_MAX) &&
                   ((valor[7:0] != numero) || !valido);
    end

    // Idle timeout counter: only runs while the bus is fully idle
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n)              tmo_cnt <= '0;
        else if (tmo_clr || tmo_hit) tmo_cnt <= '0;
        else if (tmo_inc)            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Candidate tracking and validity; published data survives errors/timeouts
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            cnt    <= '0;
            cand   <= '0;
            valido <= 1'b0;
        end else if (err_any || tmo_hit) begin
            cnt    <= '0;
            valido <= 1'b0;
        end else if (good) begin
            cand <= valor[7:0];
            cnt  <= cnt_good;
            if (publish) valido <= 1'b1;
        end
    end

    // Published value registers
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            numero   <= '0;
            ones     <= '0;
            tens     <= '0;
            hundreds <= '0;
        end else if (publish) begin
            numero   <= valor[7:0];
            ones     <= dig[0];
            tens     <= dig[1];
            hundreds <= dig[2];
        end
    end

    // Registered event pulses; publish and err_any are mutually exclusive
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            pronto <= 1'b0;
            erro   <= 1'b0;
        end else begin
            pronto <= publish;
            erro   <= err_any;
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_decodificador7seg.sv
// Directed bench for the display bus receiver.
module tb_decodificador7seg;

    localparam int TMO = 64;

    logic        clock = 1'b0;
    logic        zera_as_n;
    logic [11:0] display;
    logic [7:0]  numero;
    logic [3:0]  ones, tens, hundreds;
    logic        valido, pronto, erro;
    logic [1:0]  db_estado;

    int checks = 0, failures = 0;
    int n_pronto = 0, n_erro = 0, n_both = 0;

    decodificador7seg #(.ESTAVEIS(2), .TIMEOUT(TMO)) dut (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .display   (display),
        .numero    (numero),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .valido    (valido),
        .pronto    (pronto),
        .erro      (erro),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Pulse tallies, one sample per cycle
    always @(negedge clock) begin
        if (zera_as_n === 1'b1) begin
            if (pronto === 1'b1) n_pronto <= n_pronto + 1;
            if (erro === 1'b1)   n_erro   <= n_erro + 1;
            if (pronto === 1'b1 && erro === 1'b1) n_both <= n_both + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] en, input logic [7:0] sg);
        display = {en, sg};
        @(posedge clock);
        #1;
    endtask

    task automatic frame(input logic [7:0] h, input logic [7:0] t, input logic [7:0] o);
        cyc(4'hE, o);
        cyc(4'hD, t);
        cyc(4'hB, h);
        cyc(4'h7, 8'hFF);
    endtask

    task automatic idle(input int n);
        display = 12'hFFF;
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] bcd3(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        bcd3 = {20'd0, h, t, o};
    endfunction

    initial begin
        zera_as_n = 1'b0;
        display   = 12'hFFF;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_numero", 32'(numero), 32'd0);
        chk("rst_digits", bcd3(hundreds, tens, ones), 32'h000);
        chk("rst_flags",  {29'd0, valido, pronto, erro}, 32'd0);
        chk("rst_estado", 32'(db_estado), 32'd0);
        zera_as_n = 1'b1;
        idle(2);

        // 173 twice -> publish on the second D3 edge
        frame(8'hF9, 8'hF8, 8'hB0);
        chk("f1_pronto", 32'(pronto), 32'd0);
        chk("f1_estado", 32'(db_estado), 32'd0);
        frame(8'hF9, 8'hF8, 8'hB0);
        chk("f2_pronto", 32'(pronto), 32'd1);
        chk("f2_numero", 32'(numero), 32'd173);
        chk("f2_digits", bcd3(hundreds, tens, ones), 32'h173);
        chk("f2_valido", 32'(valido), 32'd1);
        frame(8'hF9, 8'hF8, 8'hB0);
        chk("f3_pronto", 32'(pronto), 32'd0);

        // 42 then 173: candidate restarts each time, nothing published
        frame(8'hC0, 8'h99, 8'hA4);
        chk("f42_pronto", 32'(pronto), 32'd0);
        frame(8'hF9, 8'hF8, 8'hB0);
        chk("f173b_pronto", 32'(pronto), 32'd0);
        chk("f173b_numero", 32'(numero), 32'd173);

        // Illegal tens glyph 'A'
        frame(8'hF9, 8'h88, 8'hB0);
        chk("bad_erro",   32'(erro), 32'd1);
        chk("bad_valido", 32'(valido), 32'd0);
        chk("bad_pronto", 32'(pronto), 32'd0);
        frame(8'hF9, 8'hF8, 8'hB0);
        chk("rep1_pronto", 32'(pronto), 32'd0);
        frame(8'hF9, 8'hF8, 8'hB0);
        chk("rep2_pronto", 32'(pronto), 32'd1);
        chk("rep2_valido", 32'(valido), 32'd1);

        // D1 skipped: error, back to ESPERA_D0, next D0 accepted
        cyc(4'hE, 8'hB0);
        cyc(4'hB, 8'hF9);
        chk("skip_erro",   32'(erro), 32'd1);
        chk("skip_estado", 32'(db_estado), 32'd0);
        cyc(4'hE, 8'hB0);
        chk("skip_d0_estado", 32'(db_estado), 32'd1);
        chk("skip_d0_erro",   32'(erro), 32'd0);
        cyc(4'hD, 8'hF8);
        cyc(4'hB, 8'hF9);
        cyc(4'h7, 8'hFF);
        chk("skip_tail_erro",   32'(erro), 32'd0);
        chk("skip_tail_pronto", 32'(pronto), 32'd0);

        // Malformed nibble
        cyc(4'h0, 8'hFF);
        chk("nib0_erro",   32'(erro), 32'd1);
        chk("nib0_estado", 32'(db_estado), 32'd0);

        // 999 exceeds 8 bits
        frame(8'h90, 8'h90, 8'h90);
        chk("f999_erro", 32'(erro), 32'd1);

        // 255 is the largest publishable value
        frame(8'hA4, 8'h92, 8'h92);
        chk("f255a_pronto", 32'(pronto), 32'd0);
        frame(8'hA4, 8'h92, 8'h92);
        chk("f255_pronto", 32'(pronto), 32'd1);
        chk("f255_numero", 32'(numero), 32'd255);
        chk("f255_digits", bcd3(hundreds, tens, ones), 32'h255);

        // Timeout mid-frame: valido drops on the TMO-th idle cycle, data held
        cyc(4'hE, 8'hA4);
        idle(TMO - 1);
        chk("tmo_pre_valido", 32'(valido), 32'd1);
        chk("tmo_pre_estado", 32'(db_estado), 32'd1);
        idle(1);
        chk("tmo_valido", 32'(valido), 32'd0);
        chk("tmo_estado", 32'(db_estado), 32'd0);
        chk("tmo_numero", 32'(numero), 32'd255);

        // Asynchronous reset mid-frame
        cyc(4'hE, 8'hB0);
        cyc(4'hD, 8'hF8);
        zera_as_n = 1'b0;
        #2;
        chk("arst_numero", 32'(numero), 32'd0);
        chk("arst_digits", bcd3(hundreds, tens, ones), 32'h000);
        chk("arst_estado", 32'(db_estado), 32'd0);
        chk("arst_valido", 32'(valido), 32'd0);
        idle(1);
        zera_as_n = 1'b1;
        idle(1);
        frame(8'hF9, 8'hF8, 8'hB0);
        chk("post_f1_pronto", 32'(pronto), 32'd0);
        frame(8'hF9, 8'hF8, 8'hB0);
        chk("post_f2_pronto", 32'(pronto), 32'd1);
        chk("post_f2_numero", 32'(numero), 32'd173);

        idle(2);
        chk("tot_pronto", 32'(n_pronto), 32'd4);
        chk("tot_erro",   32'(n_erro),   32'd4);
        chk("tot_both",   32'(n_both),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decodificador7seg.md
# decodificador7seg

Receiving end of the multiplexed 7-segment display bus: samples the 12-bit `display` word (active-low digit enables plus active-low segments), reassembles one scan frame of ones/tens/hundreds, decodes segment patterns back to BCD and binary, and publishes a value only after it has been stable for a programmable number of frames. It sits wherever a display bus must be read back, such as a second board or a self-check/debug path. It gives a registered 8-bit number, BCD digits, a `pronto` pulse and an `erro` pulse.

## Interface
- `ESTAVEIS`, 2: consecutive identical good frames required before publishing (1..15).
- `TIMEOUT`, 64: cycles without any valid enable before `valido` drops (≥8).
- `clock`  in  1  rising-edge clock, the same clock as the display driver.
- `zera_as_n`  in  1  asynchronous, active-low reset.
- `display`  in  12  [11:8] active-low one-hot digit enable (1110=ones, 1101=tens, 1011=hundreds, 0111=pos3); [7:0] active-low segments {dp,g,f,e,d,c,b,a}.
- `numero`  out  8  published binary value.
- `ones`, `tens`, `hundreds`  out  4 each  published BCD digits.
- `valido`  out  1  level: published value is current.
- `pronto`  out  1  one-cycle pulse when a value is published.
- `erro`  out  1  one-cycle pulse on a bad frame.
- `db_estado`  out  2  FSM state (debug).

## Operation
- Segment codes 0..9: C0,F9,A4,B0,99,92,82,F8,80,90. Blank: FF. Any other pattern (letters, dp lit) is illegal.
- FSM states and encoding: ESPERA_D0=0, ESPERA_D1=1, ESPERA_D2=2, ESPERA_D3=3. Each cycle the enable nibble is classified:
  - 1111 (idle): hold state; timeout counter increments.
  - One-hot-low and equal to the expected position: capture the segment byte and advance; D3 wraps to D0.
  - One-hot-low but not the expected position: `erro` pulse, and the frame is discarded. If the enable is 1110, capture it as D0 and go to ESPERA_D1; otherwise go to ESPERA_D0.
  - Any other nibble (0000, two low, etc.): `erro` pulse, go to ESPERA_D0.
  - Any valid enable clears the timeout counter.
- Frame evaluation happens on the D3 edge. The frame is good if D0..D2 decode to digits and D3 == FF; otherwise `erro` pulses.
- Value computation: value = hundreds·100 + tens·10 + ones, in 10 bits. A value above 255 is an error frame.
- Stability counter `cnt` (4 bits):
  - Good frame equal to the last candidate: `cnt` = min(`cnt`+1, `ESTAVEIS`).
  - Good frame with a different value: candidate = new value, `cnt`=1.
  - Error frame: `cnt`=0 and `valido`=0.
- Publish when `cnt` reaches `ESTAVEIS` on this edge and (value ≠ published value or `valido`=0):
  - update `numero`, `ones`, `tens`, `hundreds`;
  - set `valido`=1;
  - pulse `pronto`.
- Timeout: when the counter reaches `TIMEOUT`, set `valido`=0, `cnt`=0, state ESPERA_D0. Published data holds.

## Timing
- Reset values: `numero`=0, all digits 0, `valido`=0, `pronto`=0, `erro`=0, `db_estado`=0, `cnt`=0.
- Latency: `pronto`/`erro` are registered and high during the cycle after the D3 sample edge (or after the offending sample). Data is valid in the same cycle as `pronto` and holds until the next publish.
- A driver advancing every clock gives 4-cycle frames. With `ESTAVEIS`=2, `pronto` arrives 8 cycles after the first D0 sample.
- `pronto` and `erro` are never both high.
- Reset mid-frame discards partial captures immediately.

## Structure
- Shared package holds:
  - segment code constants (digits 0..9, blank);
  - enable patterns;
  - FSM state encoding.
- Sub-module `sevenSeg2bcd`: combinational segment byte → {legal, bcd[3:0]}. Instantiate it three times or once per capture.

## Test plan
- 173 frames {E,B0},{D,F8},{B,F9},{7,FF} ×2 with `ESTAVEIS`=2 → `pronto` once, `numero`=173, `hundreds`/`tens`/`ones`=1/7/3, `valido`=1. A third identical frame gives no `pronto`.
- After 173 is published, one frame of 42 then 173 again → no publish, `cnt` restarts each time, `numero` stays 173.
- Tens segment 0x88 ('A') → `erro` one cycle after the D3 edge, `valido`=0. The next two good 173 frames republish with `pronto`.
- Enable sequence 1110,1011 (D2 skipped over D1) → `erro`, state ESPERA_D0. A following 1110 is accepted as D0.
- 999 frame (90,90,90) → `erro` (value over 255). Frame 255 → publishes 255.
- Enables held at 1111 for `TIMEOUT` cycles → `valido`=0, data held. `zera_as_n` low mid-frame → all outputs zero asynchronously.
